avalon_multi_timer: RTL
=======================

# avalon_multi_timer

Parametrised successor to the single-channel high-resolution interval timer: NUM_CH independent down-counting channels of CNT_W bits each, behind one 16-bit Avalon-MM slave. Each channel adds an optional tick prescaler and a per-channel interrupt enable bit. The block sits on the system bus next to the UDP/Ethernet control logic. It provides periodic ticks, one-shot timeouts and free-running snapshots, and raises one combined level interrupt.

## Interface
- NUM_CH, 4: number of channels, 1..8
- CNT_W, 32: counter/period width per channel, 17..32
- RESET_PERIOD, 32'h270FF: period and counter reset value (truncated to CNT_W)
- ADDR_W, 3+$clog2(NUM_CH): word address width (derived, not overridden)
- clk  in  1  system clock; everything is synchronous to its rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address: upper bits select the channel, low 3 bits select the register offset
- chipselect  in  1  slave select
- write_n  in  1  active-low write; a write occurs when chipselect && !write_n
- writedata  in  16  write data
- readdata  out  16  registered read data; reset 0
- irq  out  1  OR over channels of (TO && ITO); reset 0

## Operation
- Per-channel register offsets:
  - 0 STATUS: bit0 TO, bit1 RUN. A write of any value clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Only bits [1:0] are stored; START and STOP are write strobes and read back 0.
  - 2 PERIOD_L, 3 PERIOD_H: the period. Bits above CNT_W are ignored on write and read back 0.
  - 4 SNAP_L, 5 SNAP_H: any write to either offset copies the live counter into the snapshot. Reads return the snapshot.
  - 6 PRESCALE: 16-bit value P.
  - 7 PEND: read-only bitmap of {TO} across all channels. The same value is returned at offset 7 of every channel.
- Unused channel addresses (channel index ≥ NUM_CH) read 0; writes to them are ignored.
- Counter:
  - Reset loads RESET_PERIOD and RUN=0.
  - While RUN=1, on each tick: if counter==0, load PERIOD; else decrement.
  - If CONT=0, reaching 0 clears RUN.
- Writing PERIOD_L or PERIOD_H clears RUN. On the next cycle it forces a reload of the counter from PERIOD, and the prescaler also reloads.
- START and STOP written together: START wins. START while already running leaves the counter value unchanged.
- Timeout event is the rising edge of (counter==0), tracked with a registered copy of zero. The event sets TO.
- STATUS write and timeout event in the same cycle: the clear wins and TO=0.
- Snapshot write in the same cycle as a decrement captures the pre-edge counter value.

## Timing
- Write to a register takes effect at the clock edge where the strobe is sampled.
- readdata is registered from the address decode every cycle, independent of chipselect. Read latency is 1 cycle.
- START sampled at edge t gives RUN=1 after t. The first decrement happens at the first tick after t.
- Tick generation:
  - With prescaler: a tick occurs every P+1 clocks. The prescale count restarts at START and at any forced reload. P=0 gives a tick every clock.
  - Interval between timeout events: (PERIOD+1)·(P+1) clocks in continuous mode.
- Timing of TO and irq:
  - TO is set 1 cycle after the counter first reads 0.
  - irq goes high in the same cycle as TO when ITO=1.
  - irq drops the cycle after a clearing write.
- Reset asserted mid-count returns all state to reset values asynchronously. readdata=0 and irq=0 immediately.

## Configuration
- AVALON_MULTI_TIMER_PRESCALE_EN defined: the per-channel 16-bit prescaler and offset 6 exist as described.
- Not defined: there is no prescaler logic, every clock is a tick, and offset 6 reads 0 with writes ignored. All other behaviour is identical.

## Structure
- Package avalon_multi_timer_pkg holds:
  - register offset localparams (OFF_STATUS..OFF_PEND)
  - CONTROL/STATUS bit-index constants
  - the max-channel constant (8)
- Sub-module avalon_multi_timer_channel contains one channel: counter, prescaler, period/snapshot/control registers, TO/RUN and the local read mux. It is instantiated NUM_CH times with a generate loop.
- The top level contains the address decode, the channel-select read mux, the readdata register, the PEND bitmap and the irq OR.

## Test plan
- Reset: readdata=0, irq=0. Channel 0 PERIOD reads 0x70FF/0x0002. STATUS reads 0.
- Continuous mode, no prescale:
  - Stimulus: ch1 PERIOD=4, P=0, CONTROL=0x7 (ITO|CONT|START).
  - Expected: counter runs 4,3,2,1,0,4…; TO and irq set every 5 clocks; a STATUS write clears irq the next cycle.
- One-shot with prescale: ch2 PERIOD=2, P=3, CONTROL=0x4. Expected: RUN clears after 12 clocks, exactly one TO, irq stays 0 (ITO=0), PEND=0x04.
- Collisions:
  - A STATUS write in the same cycle as a timeout event leaves TO=0.
  - A CONTROL write of 0xC (START and STOP together) leaves RUN=1.
- Reload and snapshot: a PERIOD_L write while running gives RUN=0 and counter=new PERIOD after the next cycle. Snapshot at counter 0x0001_2345 reads 0x2345/0x0001.
- Macro off: offset 6 reads 0. With PERIOD=3, timeouts occur every 4 clocks regardless of writes to offset 6.

Source files
------------

// File: rtl/avalon_multi_timer_pkg.sv
// Shared constants and types for the multi-channel Avalon-MM interval timer.
package avalon_multi_timer_pkg;

    localparam int MAX_CH = 8;

    localparam logic [2:0] OFF_STATUS   = 3'd0;
    localparam logic [2:0] OFF_CONTROL  = 3'd1;
    localparam logic [2:0] OFF_PERIOD_L = 3'd2;
    localparam logic [2:0] OFF_PERIOD_H = 3'd3;
    localparam logic [2:0] OFF_SNAP_L   = 3'd4;
    localparam logic [2:0] OFF_SNAP_H   = 3'd5;
    localparam logic [2:0] OFF_PRESCALE = 3'd6;
    localparam logic [2:0] OFF_PEND     = 3'd7;

    localparam int STS_TO    = 0;
    localparam int STS_RUN   = 1;
    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // Write request as seen by one channel after address decode.
    typedef struct packed {
        logic        wr;
        logic [2:0]  off;
        logic [15:0] data;
    } chan_req_t;

endpackage

// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel timer.
interface avalon_multi_timer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_multi_timer_channel.sv
// One timer channel: counter, optional prescaler, registers, TO/RUN and local read mux.
// Prescaler present only when AVALON_MULTI_TIMER_PRESCALE_EN is defined.
module avalon_multi_timer_channel
    import avalon_multi_timer_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h270FF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  chan_req_t   req,
    input  logic [2:0]  rd_off,
    output logic [15:0] rdata,
    output logic        to,
    output logic        ito
);
    localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

    logic [CNT_W-1:0] cnt, period, snap;
    logic [31:0]      period32, snap32, period_w;
    logic             cont, run, zero, zero_q, reload, tick, start;
    logic             wr_status, wr_ctrl, wr_period, wr_snap;

    assign wr_status = req.wr && (req.off == OFF_STATUS);
    assign wr_ctrl   = req.wr && (req.off == OFF_CONTROL);
    assign wr_period = req.wr && (req.off == OFF_PERIOD_L || req.off == OFF_PERIOD_H);
    assign wr_snap   = req.wr && (req.off == OFF_SNAP_L || req.off == OFF_SNAP_H);
    assign start     = wr_ctrl && req.data[CTL_START];
    assign zero      = (cnt == '0);
    assign period32  = 32'(period);
    assign snap32    = 32'(snap);

    always_comb begin
        period_w = period32;
        if (req.off == OFF_PERIOD_L) period_w[15:0]  = req.data;
        else                         period_w[31:16] = req.data;
    end

`ifdef AVALON_MULTI_TIMER_PRESCALE_EN
    logic [15:0] presc, pcnt;

    // pcnt counts down from P; the tick fires when it hits 0, giving one tick per P+1 clocks.
    assign tick = run && (pcnt == 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            pcnt  <= '0;
        end else begin
            if (req.wr && req.off == OFF_PRESCALE) presc <= req.data;
            if (reload || start || tick) pcnt <= presc;
            else if (run)                pcnt <= pcnt - 16'd1;
        end
    end
`else
    assign tick = run;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= RST_CNT;
            period <= RST_CNT;
            snap   <= '0;
            ito    <= 1'b0;
            cont   <= 1'b0;
            run    <= 1'b0;
            to     <= 1'b0;
            zero_q <= (RST_CNT == '0);
            reload <= 1'b0;
        end else begin
            zero_q <= zero;
            reload <= wr_period;
            if (reload)    cnt <= period;
            else if (tick) cnt <= zero ? period : cnt - CNT_W'(1);
            // One-shot ends on the wrap tick, leaving the counter reloaded for a restart.
            if (tick && zero && !cont) run <= 1'b0;
            if (wr_period) begin
                period <= period_w[CNT_W-1:0];
                run    <= 1'b0;
            end
            if (wr_ctrl) begin
                ito  <= req.data[CTL_ITO];
                cont <= req.data[CTL_CONT];
                if (start)                      run <= 1'b1;
                else if (req.data[CTL_STOP])    run <= 1'b0;
            end
            if (wr_snap) snap <= cnt;
            if (wr_status)          to <= 1'b0;
            else if (zero && !zero_q) to <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (rd_off)
            OFF_STATUS: begin
                rdata[STS_TO]  = to;
                rdata[STS_RUN] = run;
            end
            OFF_CONTROL: begin
                rdata[CTL_ITO]  = ito;
                rdata[CTL_CONT] = cont;
            end
            OFF_PERIOD_L: rdata = period32[15:0];
            OFF_PERIOD_H: rdata = period32[31:16];
            OFF_SNAP_L:   rdata = snap32[15:0];
            OFF_SNAP_H:   rdata = snap32[31:16];
`ifdef AVALON_MULTI_TIMER_PRESCALE_EN
            OFF_PRESCALE: rdata = presc;
`endif
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/avalon_multi_timer.sv
// NUM_CH-channel down-counting timer behind a 16-bit Avalon-MM slave with one combined irq.
// Build option: AVALON_MULTI_TIMER_PRESCALE_EN enables the per-channel tick prescaler.
module avalon_multi_timer
    import avalon_multi_timer_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h270FF,
    localparam int         ADDR_W       = 3 + $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_multi_timer_if.slave bus,
    output logic                irq
);
    localparam int CSEL_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;
    localparam int NSLOT  = 1 << CSEL_W;

    logic [CSEL_W-1:0] ch_sel;
    logic [2:0]        off;
    logic              wr;
    logic [NUM_CH-1:0] to_vec, ito_vec;
    logic [MAX_CH-1:0] pend;
    logic [15:0]       slot_rd [NSLOT];
    logic [15:0]       rd_nxt;

    assign off  = bus.address[2:0];
    assign wr   = bus.chipselect && !bus.write_n;
    assign pend = MAX_CH'(to_vec);
    assign irq  = |(to_vec & ito_vec);

    if (ADDR_W > 3) begin : g_sel
        assign ch_sel = bus.address[ADDR_W-1:3];
    end else begin : g_nosel
        assign ch_sel = '0;
    end

    // Slots past NUM_CH exist only so the read mux index is always in range.
    for (genvar i = 0; i < NSLOT; i++) begin : g_ch
        if (i < NUM_CH) begin : g_live
            chan_req_t req;
            assign req = '{wr: wr && (ch_sel == CSEL_W'(i)), off: off, data: bus.writedata};
            avalon_multi_timer_channel #(
                .CNT_W        (CNT_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .req     (req),
                .rd_off  (off),
                .rdata   (slot_rd[i]),
                .to      (to_vec[i]),
                .ito     (ito_vec[i])
            );
        end else begin : g_empty
            assign slot_rd[i] = '0;
        end
    end

    always_comb begin
        rd_nxt = '0;
        if (int'(ch_sel) < NUM_CH)
            rd_nxt = (off == OFF_PEND) ? 16'(pend) : slot_rd[ch_sel];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_nxt;
    end

endmodule
